// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit-side blocks.
//   tx_state_e        - one-hot launch FSM state (4 bits)
//   DEF_DATA_BITS     - default character width
//   DEF_DEPTH         - default transmit FIFO depth (power of two, >= 2)
package uart_pkg;

  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_DEPTH     = 16;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'b0001,
    ST_LAUNCH    = 4'b0010,
    ST_WAIT_BUSY = 4'b0100,
    ST_WAIT_DONE = 4'b1000
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count.
//   clk, rst      - clock, asynchronous active-high reset
//   push, din     - write strobe and data (ignored while full)
//   pop           - remove head entry (ignored while empty)
//   dout          - head entry (valid while not empty)
//   full, empty   - decoded from the registered count
//   count         - occupancy, 0..DEPTH
// Pointers are log2(DEPTH) bits and wrap naturally; a separate count
// disambiguates full from empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CNT_FULL);
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign dout      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage write; contents need no reset because the count gates reads.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; push+pop together keeps the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: character FIFO in front of a UART transmitter, with a
// launch FSM that hands one character at a time to the transmitter.
//   clk, rst          - clock, asynchronous active-high reset
//   i_data_valid      - producer write strobe (dropped while o_ready low)
//   i_data            - producer character
//   o_ready           - FIFO not full
//   o_empty           - FIFO holds no characters
//   o_tx_data_valid   - one-cycle launch strobe to transmitter i_data_valid
//   o_tx_data         - launched character, held until the next launch
//   i_tx_busy         - transmitter o_busy
//   o_level           - occupancy; only when UART_TX_FIFO_LEVEL_EN is defined
// Optional feature macro: UART_TX_FIFO_LEVEL_EN.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int DEPTH     = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_data_valid,
  input  logic [DATA_BITS-1:0]   i_data,
  output logic                   o_ready,
  output logic                   o_empty,
  output logic                   o_tx_data_valid,
  output logic [DATA_BITS-1:0]   o_tx_data,
  input  logic                   i_tx_busy
`ifdef UART_TX_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] o_level
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  tx_state_e              state_r;
  tx_state_e              next_s;
  logic                   launch_s;
  logic                   pop_s;
  logic                   full_s;
  logic                   empty_s;
  logic [CNT_W-1:0]       count_s;
  logic [DATA_BITS-1:0]   head_s;
  logic                   valid_r;
  logic [DATA_BITS-1:0]   data_r;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (i_data_valid),
    .din   (i_data),
    .pop   (pop_s),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  assign o_ready         = !full_s;
  assign o_empty         = empty_s;
  assign o_tx_data_valid = valid_r;
  assign o_tx_data       = data_r;
`ifdef UART_TX_FIFO_LEVEL_EN
  assign o_level         = count_s;
`endif

  // Launch FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next state; launch_s fires on the IDLE->LAUNCH transition so the
  // registered strobe is high exactly during the LAUNCH cycle.
  always_comb begin
    next_s   = state_r;
    launch_s = 1'b0;
    pop_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if ((count_s != {CNT_W{1'b0}}) && !i_tx_busy) begin
          next_s   = ST_LAUNCH;
          launch_s = 1'b1;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        pop_s  = 1'b1;
        next_s = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        // Busy rises one cycle after the strobe; wait for it.
        if (i_tx_busy) begin
          next_s = ST_WAIT_DONE;
        end else begin
          next_s = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_DONE: begin
        if (!i_tx_busy) begin
          next_s = ST_IDLE;
        end else begin
          next_s = ST_WAIT_DONE;
        end
      end
      default: begin
        next_s = ST_IDLE;
      end
    endcase
  end

  // Output registers: strobe for one cycle, character held until next launch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
      data_r  <= {DATA_BITS{1'b0}};
    end else begin
      valid_r <= launch_s;
      if (launch_s) begin
        data_r <= head_s;
      end else begin
        data_r <= data_r;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_data_valid = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       i_tx_busy = 1'b0;
  logic       o_ready;
  logic       o_empty;
  logic       o_tx_data_valid;
  logic [7:0] o_tx_data;
`ifdef UART_TX_FIFO_LEVEL_EN
  logic [4:0] o_level;
`endif

  uart_tx_fifo #(.DATA_BITS(8), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_data_valid    (i_data_valid),
    .i_data          (i_data),
    .o_ready         (o_ready),
    .o_empty         (o_empty),
    .o_tx_data_valid (o_tx_data_valid),
    .o_tx_data       (o_tx_data),
    .i_tx_busy       (i_tx_busy)
`ifdef UART_TX_FIFO_LEVEL_EN
    ,
    .o_level         (o_level)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: queued characters plus the handshake of the one
  // character currently handed to the transmitter.
  logic [7:0] q[$];
  bit         m_strobe;      // strobe visible this cycle
  bit         m_await_rise;  // handed over, busy not yet seen
  bit         m_await_fall;  // transmitter busy with our character
  logic [7:0] m_data;
  int         n_acc;

  // Transmitter model and observation.
  logic [7:0] got[$];
  int         busy_left;
  int         tx_len = 10;
  bit         rise_pending;
  bit         force_busy;
  bit         rand_len;
  bit         prev_busy;

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       busy;
    logic       ev;
    logic [7:0] ed;
    logic       er;
    logic       ee;
  } vec_t;
  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_strobe = 1'b0;
    m_await_rise = 1'b0;
    m_await_fall = 1'b0;
    m_data = 8'h00;
    n_acc = 0;
  endtask

  // Advance the model over one clock edge using the inputs now applied.
  task automatic model_step();
    bit         free;
    bit         start;
    bit         wr_ok;
    logic [7:0] nd;
    free  = !m_strobe && !m_await_rise && !m_await_fall;
    start = free && (q.size() != 0) && !i_tx_busy;
    wr_ok = i_data_valid && (q.size() < DEPTH);
    nd    = start ? q[0] : m_data;
    if (m_strobe) void'(q.pop_front());
    if (wr_ok) begin
      q.push_back(i_data);
      n_acc++;
    end
    m_await_fall = (m_await_rise || m_await_fall) && i_tx_busy;
    m_await_rise = m_strobe || (m_await_rise && !i_tx_busy);
    m_strobe     = start;
    m_data       = nd;
  endtask

  task automatic compare_model();
    check("valid", 32'(o_tx_data_valid), 32'(m_strobe));
    check("data", 32'(o_tx_data), 32'(m_data));
    check("ready", 32'(o_ready), 32'(q.size() != DEPTH));
    check("empty", 32'(o_empty), 32'(q.size() == 0));
`ifdef UART_TX_FIFO_LEVEL_EN
    check("level", 32'(o_level), 32'(q.size()));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock with model comparison and transmitter response.
  task automatic cycle(input logic wr, input logic [7:0] d);
    i_data_valid = wr;
    i_data = d;
    model_step();
    tick();
    compare_model();
    if (o_tx_data_valid) got.push_back(o_tx_data);
    prev_busy = i_tx_busy;
    if (busy_left > 0) busy_left--;
    if (rise_pending) begin
      busy_left = tx_len;
      rise_pending = 1'b0;
    end
    if (o_tx_data_valid) begin
      rise_pending = 1'b1;
      if (rand_len) tx_len = $urandom_range(1, 6);
    end
    i_tx_busy = force_busy || (busy_left > 0);
    if (o_tx_data_valid) check("strobe_quiet", 32'({i_tx_busy, prev_busy}), 32'd0);
    i_data_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_data_valid = 1'b0;
    busy_left = 0;
    rise_pending = 1'b0;
    force_busy = 1'b0;
    i_tx_busy = 1'b0;
    prev_busy = 1'b0;
    model_reset();
    got.delete();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input int n, input int bound);
    int c = 0;
    while (got.size() < n && c < bound) begin
      cycle(1'b0, 8'h00);
      c++;
    end
    for (int k = 0; k < 25; k++) cycle(1'b0, 8'h00);
    check("drain_count", 32'(got.size()), 32'(n));
  endtask

  initial begin
    // {wr, data, busy} -> {valid, tx_data, ready, empty} after the edge
    vecs[0]  = '{1'b1, 8'h55, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h55, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h55, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h55, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1};

    // Reset state while held
    tick();
    tick();
    check("rst_valid", 32'(o_tx_data_valid), 32'd0);
    check("rst_data", 32'(o_tx_data), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_empty", 32'(o_empty), 32'd1);
`ifdef UART_TX_FIFO_LEVEL_EN
    check("rst_level", 32'(o_level), 32'd0);
`endif
    rst = 1'b0;

    // Table: single character latency and busy handshake
    for (int i = 0; i < 11; i++) begin
      i_data_valid = vecs[i].wr;
      i_data = vecs[i].d;
      i_tx_busy = vecs[i].busy;
      tick();
      check($sformatf("vec%0d_valid", i), 32'(o_tx_data_valid), 32'(vecs[i].ev));
      check($sformatf("vec%0d_data", i), 32'(o_tx_data), 32'(vecs[i].ed));
      check($sformatf("vec%0d_ready", i), 32'(o_ready), 32'(vecs[i].er));
      check($sformatf("vec%0d_empty", i), 32'(o_empty), 32'(vecs[i].ee));
    end
    i_data_valid = 1'b0;
    i_tx_busy = 1'b0;

    // Fill to full with busy held, drop the 17th write, then drain in order
    do_reset();
    tx_len = 10;
    force_busy = 1'b1;
    i_tx_busy = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check("fill_ready", 32'(o_ready), 32'd1);
      cycle(1'b1, 8'(k));
    end
    check("full_ready", 32'(o_ready), 32'd0);
    cycle(1'b1, 8'hAA);
    check("drop_ready", 32'(o_ready), 32'd0);
    force_busy = 1'b0;
    i_tx_busy = 1'b0;
    drain(16, 800);
    for (int k = 0; k < 16 && k < got.size(); k++) check("fill_order", 32'(got[k]), 32'(k));

    // Three characters against a 10-cycle busy transmitter
    do_reset();
    tx_len = 10;
    for (int k = 0; k < 3; k++) cycle(1'b1, 8'(8'h30 + k));
    drain(3, 200);
    for (int k = 0; k < 3 && k < got.size(); k++) check("busy3_order", 32'(got[k]), 32'(8'h30 + k));

    // count=15 with a write in the launch cycle, order kept across wrap
    do_reset();
    force_busy = 1'b1;
    i_tx_busy = 1'b1;
    for (int k = 0; k < 15; k++) cycle(1'b1, 8'(8'h10 + k));
    force_busy = 1'b0;
    i_tx_busy = 1'b0;
    cycle(1'b0, 8'h00);
    check("wrap_launch", 32'(o_tx_data_valid), 32'd1);
    cycle(1'b1, 8'h1F);
    check("wrap_ready", 32'(o_ready), 32'd1);
`ifdef UART_TX_FIFO_LEVEL_EN
    check("wrap_level", 32'(o_level), 32'd15);
`endif
    drain(16, 800);
    for (int k = 0; k < 16 && k < got.size(); k++) check("wrap_order", 32'(got[k]), 32'(8'h10 + k));

    // Asynchronous reset while waiting for busy to fall, 5 queued
    do_reset();
    tx_len = 10;
    for (int k = 0; k < 6; k++) cycle(1'b1, 8'(8'h60 + k));
    check("pre_rst_busy", 32'(i_tx_busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(o_tx_data_valid), 32'd0);
    check("arst_data", 32'(o_tx_data), 32'd0);
    check("arst_ready", 32'(o_ready), 32'd1);
    check("arst_empty", 32'(o_empty), 32'd1);
`ifdef UART_TX_FIFO_LEVEL_EN
    check("arst_level", 32'(o_level), 32'd0);
`endif
    busy_left = 0;
    rise_pending = 1'b0;
    i_tx_busy = 1'b0;
    model_reset();
    got.delete();
    tick();
    check("hold_rst_valid", 32'(o_tx_data_valid), 32'd0);
    check("hold_rst_empty", 32'(o_empty), 32'd1);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) cycle(1'b0, 8'h00);
    check("post_rst_no_strobe", 32'(got.size()), 32'd0);
    cycle(1'b1, 8'h77);
    drain(1, 100);
    if (got.size() > 0) check("post_rst_char", 32'(got[0]), 32'h77);

    // Level 0 -> 3 -> 0
    do_reset();
    force_busy = 1'b1;
    i_tx_busy = 1'b1;
    for (int k = 0; k < 3; k++) cycle(1'b1, 8'(8'hC0 + k));
`ifdef UART_TX_FIFO_LEVEL_EN
    check("level3", 32'(o_level), 32'd3);
`endif
    check("level3_empty", 32'(o_empty), 32'd0);
    force_busy = 1'b0;
    i_tx_busy = 1'b0;
    drain(3, 200);
`ifdef UART_TX_FIFO_LEVEL_EN
    check("level0", 32'(o_level), 32'd0);
`endif
    check("level0_empty", 32'(o_empty), 32'd1);

    // Randomized traffic against the model
    do_reset();
    rand_len = 1'b1;
    tx_len = 3;
    for (int k = 0; k < 600; k++) begin
      cycle(($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0, 8'($urandom));
    end
    begin
      int guard = 0;
      while ((q.size() != 0 || m_strobe || m_await_rise || m_await_fall || busy_left > 0) && guard < 3000) begin
        cycle(1'b0, 8'h00);
        guard++;
      end
      check("rand_drain_bound", 32'(guard < 3000), 32'd1);
    end
    check("rand_strobes", 32'(got.size()), 32'(n_acc));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
